cdr_loop_ctrl: RTL and testbench

Sequencing controller for the bang-bang CDR loop filter. Takes raw early/late phase-detector votes, clears the loop filter at start-up, forwards every vote during acquisition, then gear-shifts to decimated majority votes in tracking once a lock detector sees a balanced vote stream. Drops back to acquisition on loss of lock. Sits between the phase detector and the loop filter's clear/enable/R/V inputs.

---
 rtl/cdr_loop_ctrl_if.sv | 26 ++
 rtl/cdr_loop_ctrl.sv | 176 +++++++++++++++++
 tb/tb_cdr_loop_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/cdr_loop_ctrl_if.sv
// Vote and loop-filter control bundle between the phase detector, the
// sequencing controller and the bang-bang loop filter.
interface cdr_loop_ctrl_if;
  logic       start;
  logic       abort;
  logic       vld;
  logic       early;
  logic       late;
  logic       lf_rst;
  logic       lf_en;
  logic       lf_r;
  logic       lf_v;
  logic       gear;
  logic       locked;
  logic [1:0] state;

  modport master (
    output start, abort, vld, early, late,
    input  lf_rst, lf_en, lf_r, lf_v, gear, locked, state
  );

  modport slave (
    input  start, abort, vld, early, late,
    output lf_rst, lf_en, lf_r, lf_v, gear, locked, state
  );
endinterface

// File: rtl/cdr_loop_ctrl.sv
// Bang-bang CDR loop sequencer: clears the loop filter, forwards raw votes in
// acquisition, and gear-shifts to decimated majority votes once lock is seen.
module cdr_loop_ctrl #(
  parameter int WIN        = 64,
  parameter int TRK_DIV    = 4,
  parameter int LOCK_THR   = 8,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_THR = 24
) (
  input logic            clk,
  input logic            rst_n,
  cdr_loop_ctrl_if.slave bus
);

  localparam int WW  = $clog2(WIN);
  localparam int NW  = WW + 2;
  localparam int DCW = $clog2(TRK_DIV);
  localparam int DW  = DCW + 2;
  localparam int QW  = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ACQ   = 2'd2,
    TRACK = 2'd3
  } state_t;

  state_t                st;
  logic                  lf_rst, lf_en, lf_r, lf_v, gear, locked;
  logic [WW-1:0]         win_cnt;
  logic signed [NW-1:0]  net;
  logic [QW-1:0]         quiet;
  logic [DCW-1:0]        dec_cnt;
  logic signed [DW-1:0]  dec_sum;

  logic signed [NW-1:0]  vote;
  logic signed [NW-1:0]  net_next;
  logic [NW-1:0]         net_abs;
  logic signed [DW-1:0]  dec_next;
  logic                  win_end, dec_end, quiet_win;

  // Both votes high is a tie and contributes nothing to net or decimation.
  always_comb begin
    vote = '0;
    if (bus.early && !bus.late)
      vote = NW'(1);
    else if (bus.late && !bus.early)
      vote = '1;
  end

  assign net_next  = net + vote;
  assign net_abs   = net_next[NW-1] ? -net_next : net_next;
  assign dec_next  = dec_sum + $signed(vote[DW-1:0]);
  assign win_end   = bus.vld && (win_cnt == WW'(WIN - 1));
  assign dec_end   = bus.vld && (dec_cnt == DCW'(TRK_DIV - 1));
  assign quiet_win = (net_abs <= NW'(LOCK_THR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      lf_rst  <= 1'b0;
      lf_en   <= 1'b0;
      lf_r    <= 1'b0;
      lf_v    <= 1'b0;
      gear    <= 1'b0;
      locked  <= 1'b0;
      win_cnt <= '0;
      net     <= '0;
      quiet   <= '0;
      dec_cnt <= '0;
      dec_sum <= '0;
    end else if (bus.abort) begin
      st      <= IDLE;
      lf_rst  <= 1'b0;
      lf_en   <= 1'b0;
      lf_r    <= 1'b0;
      lf_v    <= 1'b0;
      gear    <= 1'b0;
      locked  <= 1'b0;
      win_cnt <= '0;
      net     <= '0;
      quiet   <= '0;
      dec_cnt <= '0;
      dec_sum <= '0;
    end else begin
      lf_rst <= 1'b0;
      lf_en  <= 1'b0;
      lf_r   <= 1'b0;
      lf_v   <= 1'b0;
      case (st)
        IDLE: begin
          if (bus.start) begin
            st     <= CLEAR;
            lf_rst <= 1'b1;
          end
        end
        CLEAR: begin
          st      <= ACQ;
          win_cnt <= '0;
          net     <= '0;
          quiet   <= '0;
          dec_cnt <= '0;
          dec_sum <= '0;
        end
        ACQ: begin
          if (bus.vld) begin
            lf_en <= 1'b1;
            lf_r  <= bus.early;
            lf_v  <= bus.late;
            if (win_end) begin
              win_cnt <= '0;
              net     <= '0;
              if (!quiet_win) begin
                quiet <= '0;
              end else if (quiet == QW'(LOCK_CNT - 1)) begin
                st      <= TRACK;
                gear    <= 1'b1;
                locked  <= 1'b1;
                quiet   <= '0;
                dec_cnt <= '0;
                dec_sum <= '0;
              end else begin
                quiet <= quiet + 1'b1;
              end
            end else begin
              win_cnt <= win_cnt + 1'b1;
              net     <= net_next;
            end
          end
        end
        TRACK: begin
          if (bus.vld) begin
            if (dec_end) begin
              dec_cnt <= '0;
              dec_sum <= '0;
              if (dec_next != '0) begin
                lf_en <= 1'b1;
                lf_r  <= !dec_next[DW-1];
                lf_v  <= dec_next[DW-1];
              end
            end else begin
              dec_cnt <= dec_cnt + 1'b1;
              dec_sum <= dec_next;
            end
            // Losing lock keeps the loop filter state; only the gear drops.
            if (win_end) begin
              win_cnt <= '0;
              net     <= '0;
              if (net_abs > NW'(UNLOCK_THR)) begin
                st      <= ACQ;
                gear    <= 1'b0;
                locked  <= 1'b0;
                quiet   <= '0;
                dec_cnt <= '0;
                dec_sum <= '0;
              end
            end else begin
              win_cnt <= win_cnt + 1'b1;
              net     <= net_next;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.lf_rst = lf_rst;
  assign bus.lf_en  = lf_en;
  assign bus.lf_r   = lf_r;
  assign bus.lf_v   = lf_v;
  assign bus.gear   = gear;
  assign bus.locked = locked;
  assign bus.state  = st;

endmodule

// File: tb/tb_cdr_loop_ctrl.sv
// Directed testbench for cdr_loop_ctrl; outputs are observed as one packed
// vector {state, lf_rst, lf_en, lf_r, lf_v, gear, locked} #1 after each edge.
module tb_cdr_loop_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;
  logic [7:0] obs;

  cdr_loop_ctrl_if bus ();

  cdr_loop_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign obs = {bus.state, bus.lf_rst, bus.lf_en, bus.lf_r, bus.lf_v, bus.gear, bus.locked};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, observed %b", obs);
    $fatal(1, "[TB] watchdog expired");
  end

  // One clock of stimulus; outputs reflect this cycle's inputs on return.
  task automatic applyStimulus(input logic s, input logic a, input logic v,
                               input logic e, input logic l);
    bus.start = s;
    bus.abort = a;
    bus.vld   = v;
    bus.early = e;
    bus.late  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 8'h00) begin
      fails++;
      $display("[TB] FAIL reset: observed %b expected %b", obs, 8'h00);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 1'b0, c[0], 1'b1, 1'b0);
      checks++;
      if (obs !== 8'h00) begin
        fails++;
        $display("[TB] FAIL idle_vote[%0d]: observed %b expected %b", c, obs, 8'h00);
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== 8'h60) begin
      fails++;
      $display("[TB] FAIL start_clear: observed %b expected %b", obs, 8'h60);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (obs !== 8'h80) begin
      fails++;
      $display("[TB] FAIL clear_to_acq: observed %b expected %b", obs, 8'h80);
    end
  endtask

  task automatic test_acq_forward;
    logic e, l, last;
    logic [7:0] exp;
    for (int i = 0; i < 256; i++) begin
      e    = (i % 2 == 0);
      l    = !e;
      last = (i == 255);
      applyStimulus(1'b0, 1'b0, 1'b1, e, l);
      exp = {last ? 2'd3 : 2'd2, 1'b0, 1'b1, e, l, last, last};
      checks++;
      if (obs !== exp) begin
        fails++;
        $display("[TB] FAIL acq_fwd[%0d]: observed %b expected %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_track_decim;
    logic [11:0] pat;
    logic e;
    logic [7:0] exp;
    pat = 12'b1000_0101_0111;
    for (int j = 0; j < 12; j++) begin
      e = pat[j];
      applyStimulus(1'b0, 1'b0, 1'b1, e, !e);
      exp = {2'd3, 1'b0, (j == 3) || (j == 11), j == 3, j == 11, 1'b1, 1'b1};
      checks++;
      if (obs !== exp) begin
        fails++;
        $display("[TB] FAIL track_decim[%0d]: observed %b expected %b", j, obs, exp);
      end
    end
    for (int i = 0; i < 52; i++) begin
      e = (i % 2 == 0);
      applyStimulus(1'b0, 1'b0, 1'b1, e, !e);
      checks++;
      if (obs !== 8'hC3) begin
        fails++;
        $display("[TB] FAIL track_balanced[%0d]: observed %b expected %b", i, obs, 8'hC3);
      end
    end
  endtask

  task automatic test_unlock;
    logic e, p, g;
    logic [7:0] exp;
    for (int i = 0; i < 64; i++) begin
      e = (i < 48);
      p = (i % 4 == 3);
      g = (i != 63);
      applyStimulus(1'b0, 1'b0, 1'b1, e, !e);
      exp = {g ? 2'd3 : 2'd2, 1'b0, p, p && e, p && !e, g, g};
      checks++;
      if (obs !== exp) begin
        fails++;
        $display("[TB] FAIL unlock[%0d]: observed %b expected %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_lock_reset;
    logic e, l, s, done;
    logic [7:0] exp;
    for (int w = 0; w < 8; w++) begin
      for (int i = 0; i < 64; i++) begin
        if (w == 3) begin
          e = (i < 40);
          l = !e;
        end else if (w == 5) begin
          e = 1'b1;
          l = (i >= 8);
        end else begin
          e = (i % 2 == 0);
          l = !e;
        end
        s    = (w == 0) && (i == 0);
        done = (w == 7) && (i == 63);
        applyStimulus(s, 1'b0, 1'b1, e, l);
        exp = {done ? 2'd3 : 2'd2, 1'b0, 1'b1, e, l, done, done};
        checks++;
        if (obs !== exp) begin
          fails++;
          $display("[TB] FAIL lock_reset[w%0d i%0d]: observed %b expected %b", w, i, obs, exp);
        end
      end
    end
  endtask

  task automatic test_abort;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (obs !== 8'hC3) begin
        fails++;
        $display("[TB] FAIL abort_pre[%0d]: observed %b expected %b", i, obs, 8'hC3);
      end
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (obs !== 8'h00) begin
      fails++;
      $display("[TB] FAIL abort_track: observed %b expected %b", obs, 8'h00);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== 8'h00) begin
      fails++;
      $display("[TB] FAIL abort_with_start: observed %b expected %b", obs, 8'h00);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== 8'h60) begin
      fails++;
      $display("[TB] FAIL restart_clear: observed %b expected %b", obs, 8'h60);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== 8'h80) begin
      fails++;
      $display("[TB] FAIL restart_acq: observed %b expected %b", obs, 8'h80);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (obs !== 8'h94) begin
      fails++;
      $display("[TB] FAIL restart_vote: observed %b expected %b", obs, 8'h94);
    end
  endtask

  initial begin
    checks    = 0;
    fails     = 0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.vld   = 1'b0;
    bus.early = 1'b0;
    bus.late  = 1'b0;
    test_reset();
    test_acq_forward();
    test_track_decim();
    test_unlock();
    test_lock_reset();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
